// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one shared column datapath,
// four cycles per 128-bit block, valid/ready on both sides.
module inv_mix_columns_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_d;
    logic [1:0]   col_cnt, col_cnt_d;
    logic [0:127] work, work_d;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m09(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] m0b(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] m0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] m0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3);
        b1 = m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3);
        b2 = m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3);
        b3 = m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Column select feeding the single shared datapath
    always_comb begin
        col_in = work[0:31];
        case (col_cnt)
            2'd0: col_in = work[0:31];
            2'd1: col_in = work[32:63];
            2'd2: col_in = work[64:95];
            2'd3: col_in = work[96:127];
            default: col_in = work[0:31];
        endcase
    end

    assign col_out = inv_mix(col_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            col_cnt <= 2'd0;
            work    <= '0;
        end else begin
            state   <= state_d;
            col_cnt <= col_cnt_d;
            work    <= work_d;
        end
    end

    always_comb begin
        state_d   = state;
        col_cnt_d = col_cnt;
        work_d    = work;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d    = in_data;
                    col_cnt_d = 2'd0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                case (col_cnt)
                    2'd0: work_d[0:31]   = col_out;
                    2'd1: work_d[32:63]  = col_out;
                    2'd2: work_d[64:95]  = col_out;
                    2'd3: work_d[96:127] = col_out;
                    default: work_d = work;
                endcase
                col_cnt_d = col_cnt + 2'd1;
                if (col_cnt == 2'd3)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = work;

endmodule
